// File: rtl/jdv_pkg.sv
// Shared definitions for the game-of-life engine: default sizes, state encoding
// and the geometry validity check.
package jdv_pkg;

  localparam int unsigned JDV_MAP_BITS = 1000;
  localparam int unsigned JDV_GEN_W    = 16;
  localparam int unsigned CRD_W        = 11;
  localparam int unsigned IDX_W        = 22;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_WAIT_VS = 2'd2;
  localparam logic [1:0] ST_COMMIT  = 2'd3;

  // Range check first so the product below never sees oversized operands.
  function automatic logic jdv_geom_ok(input logic [31:0] w, input logic [31:0] h,
                                       input int unsigned map_bits);
    logic [IDX_W-1:0] n;
    if (w < 32'd3 || h < 32'd3 || w > 32'd1000 || h > 32'd1000) return 1'b0;
    n = IDX_W'(w[CRD_W-1:0]) * IDX_W'(h[CRD_W-1:0]);
    return 32'(n) <= map_bits;
  endfunction

endpackage

// File: rtl/jdv_life_engine_neighbour_count.sv
// jdv_neighbour_count: combinational live-neighbour count for one cell.
// JDV_TORUS_EN selects wrap-around edges; otherwise off-grid cells are dead.
module jdv_neighbour_count
  import jdv_pkg::*;
#(
  parameter int unsigned MAP_BITS = JDV_MAP_BITS
) (
  input  logic [MAP_BITS-1:0] i_map,
  input  logic [IDX_W-1:0]    i_idx,
  input  logic [CRD_W-1:0]    i_h,
  input  logic [CRD_W-1:0]    i_v,
  input  logic [CRD_W-1:0]    i_w,
  input  logic [CRD_W-1:0]    i_h_max,
  output logic [3:0]          o_count
);

  localparam int unsigned AW = $clog2(MAP_BITS);

  logic [IDX_W-1:0]            w_rs_u, w_rs_c, w_rs_d;
  logic [CRD_W-1:0]            w_col_l, w_col_r;
  logic [2:0]                  w_row_ok, w_col_ok;
  logic [2:0][IDX_W-1:0]       w_rs;
  logic [2:0][CRD_W-1:0]       w_col;

  assign w_rs_c = i_idx - IDX_W'(i_h);

`ifdef JDV_TORUS_EN
  assign w_rs_u   = (i_v == '0) ? w_rs_c + IDX_W'(i_h_max - CRD_W'(1)) * IDX_W'(i_w)
                                : w_rs_c - IDX_W'(i_w);
  assign w_rs_d   = (i_v == i_h_max - CRD_W'(1)) ? '0 : w_rs_c + IDX_W'(i_w);
  assign w_col_l  = (i_h == '0) ? i_w - CRD_W'(1) : i_h - CRD_W'(1);
  assign w_col_r  = (i_h == i_w - CRD_W'(1)) ? '0 : i_h + CRD_W'(1);
  assign w_row_ok = 3'b111;
  assign w_col_ok = 3'b111;
`else
  assign w_rs_u   = w_rs_c - IDX_W'(i_w);
  assign w_rs_d   = w_rs_c + IDX_W'(i_w);
  assign w_col_l  = i_h - CRD_W'(1);
  assign w_col_r  = i_h + CRD_W'(1);
  assign w_row_ok = {i_v != i_h_max - CRD_W'(1), 1'b1, i_v != '0};
  assign w_col_ok = {i_h != i_w - CRD_W'(1), 1'b1, i_h != '0};
`endif

  // Index 0 = up/left, 1 = centre, 2 = down/right.
  assign w_rs  = {w_rs_d, w_rs_c, w_rs_u};
  assign w_col = {w_col_r, i_h, w_col_l};

  always_comb begin
    logic [IDX_W-1:0] w_x;
    o_count = '0;
    w_x     = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_x = w_rs[r] + IDX_W'(w_col[c]);
        if (!(r == 1 && c == 1) && w_row_ok[r] && w_col_ok[c] && w_x < IDX_W'(MAP_BITS)) begin
          o_count = o_count + {3'b000, i_map[w_x[AW-1:0]]};
        end
      end
    end
  end

endmodule

// File: rtl/jdv_life_engine.sv
// jdv_life_engine: game-of-life generator, one cell per clock, committed on VS rise.
// Build option JDV_TORUS_EN: neighbours wrap at the grid edges.
module jdv_life_engine
  import jdv_pkg::*;
#(
  parameter int unsigned MAP_BITS = JDV_MAP_BITS,
  parameter int unsigned GEN_W    = JDV_GEN_W
) (
  input  logic                clk_50,
  input  logic                reset,
  input  logic                step,
  input  logic                clear,
  input  logic                toggle,
  input  logic [31:0]         largeur_grille,
  input  logic [31:0]         hauteur_grille,
  input  logic [31:0]         h_position_du_curseur,
  input  logic [31:0]         v_position_du_curseur,
  input  logic                vga_vs,
  output logic [MAP_BITS-1:0] vecteur_map,
  output logic                busy,
  output logic                done,
  output logic                err_geom,
  output logic [GEN_W-1:0]    generation
);

  localparam int unsigned AW = $clog2(MAP_BITS);

  logic [1:0]          r_state;
  logic [MAP_BITS-1:0] r_map, r_shadow, w_keep;
  logic [GEN_W-1:0]    r_gen;
  logic                r_err_geom;
  logic [CRD_W-1:0]    r_w, r_hm, r_h, r_v;
  logic [IDX_W-1:0]    r_n, r_idx;
  logic                r_vs_meta, r_vs_sync, r_vs_prev;

  logic                w_idle, w_geom_ok, w_cur_in, w_last, w_vs_rise, w_next_cell;
  logic                w_do_clear, w_do_toggle, w_do_step;
  logic [IDX_W-1:0]    w_tog_idx;
  logic [3:0]          w_count;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_geom_ok = jdv_geom_ok(largeur_grille, hauteur_grille, MAP_BITS);
  assign w_cur_in  = (h_position_du_curseur < largeur_grille) &&
                     (v_position_du_curseur < hauteur_grille);
  assign w_tog_idx = IDX_W'(v_position_du_curseur[CRD_W-1:0]) *
                     IDX_W'(largeur_grille[CRD_W-1:0]) +
                     IDX_W'(h_position_du_curseur[CRD_W-1:0]);

  // One action per IDLE cycle: clear beats toggle beats step.
  assign w_do_clear  = w_idle && clear;
  assign w_do_toggle = w_idle && !clear && toggle && w_geom_ok && w_cur_in;
  assign w_do_step   = w_idle && !clear && !toggle && step && w_geom_ok;

  assign w_last      = (r_idx == r_n - IDX_W'(1));
  assign w_vs_rise   = r_vs_sync && !r_vs_prev;
  assign w_next_cell = (w_count == 4'd3) || (r_map[r_idx[AW-1:0]] && w_count == 4'd2);

  always_comb begin
    w_keep = '0;
    for (int i = 0; i < MAP_BITS; i++) w_keep[i] = (IDX_W'(i) < r_n);
  end

  jdv_neighbour_count #(
    .MAP_BITS(MAP_BITS)
  ) u_count (
    .i_map  (r_map),
    .i_idx  (r_idx),
    .i_h    (r_h),
    .i_v    (r_v),
    .i_w    (r_w),
    .i_h_max(r_hm),
    .o_count(w_count)
  );

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_vs_meta <= 1'b0;
      r_vs_sync <= 1'b0;
      r_vs_prev <= 1'b0;
    end else begin
      r_vs_meta <= vga_vs;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_map      <= '0;
      r_shadow   <= '0;
      r_gen      <= '0;
      r_err_geom <= 1'b0;
      r_w        <= '0;
      r_hm       <= '0;
      r_h        <= '0;
      r_v        <= '0;
      r_n        <= '0;
      r_idx      <= '0;
    end else begin
      r_err_geom <= !w_geom_ok;
      case (r_state)
        ST_IDLE: begin
          if (w_do_clear) begin
            r_map <= '0;
            r_gen <= '0;
          end else if (w_do_toggle) begin
            r_map[w_tog_idx[AW-1:0]] <= !r_map[w_tog_idx[AW-1:0]];
          end else if (w_do_step) begin
            r_w     <= largeur_grille[CRD_W-1:0];
            r_hm    <= hauteur_grille[CRD_W-1:0];
            r_n     <= IDX_W'(largeur_grille[CRD_W-1:0]) * IDX_W'(hauteur_grille[CRD_W-1:0]);
            r_h     <= '0;
            r_v     <= '0;
            r_idx   <= '0;
            r_state <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          r_shadow[r_idx[AW-1:0]] <= w_next_cell;
          if (w_last) begin
            r_state <= ST_WAIT_VS;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
            if (r_h == r_w - CRD_W'(1)) begin
              r_h <= '0;
              r_v <= r_v + CRD_W'(1);
            end else begin
              r_h <= r_h + CRD_W'(1);
            end
          end
        end
        ST_WAIT_VS: begin
          if (w_vs_rise) begin
            r_map   <= r_shadow & w_keep;
            r_gen   <= r_gen + GEN_W'(1);
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign vecteur_map = r_map;
  assign generation  = r_gen;
  assign err_geom    = r_err_geom;
  assign busy        = !w_idle;
  assign done        = (r_state == ST_COMMIT);

endmodule

// File: tb/tb_jdv_life_engine.sv
// Scoreboard bench for jdv_life_engine: expected commits are queued at step time
// and checked by a monitor whenever done is seen.
module tb_jdv_life_engine;

  localparam int unsigned MB = 1000;
  localparam int unsigned GW = 16;

  typedef struct {
    logic [MB-1:0] map;
    logic [GW-1:0] gen;
  } exp_t;

  logic          clk_50 = 1'b0;
  logic          reset  = 1'b1;
  logic          step   = 1'b0;
  logic          clear  = 1'b0;
  logic          toggle = 1'b0;
  logic [31:0]   largeur_grille = 32'd5;
  logic [31:0]   hauteur_grille = 32'd5;
  logic [31:0]   h_pos = 32'd0;
  logic [31:0]   v_pos = 32'd0;
  logic          vga_vs = 1'b0;
  logic [MB-1:0] vecteur_map;
  logic          busy, done, err_geom;
  logic [GW-1:0] generation;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            busy_cycles = 0;
  logic [MB-1:0] edge_exp;

  jdv_life_engine #(
    .MAP_BITS(MB),
    .GEN_W   (GW)
  ) dut (
    .clk_50               (clk_50),
    .reset                (reset),
    .step                 (step),
    .clear                (clear),
    .toggle               (toggle),
    .largeur_grille       (largeur_grille),
    .hauteur_grille       (hauteur_grille),
    .h_position_du_curseur(h_pos),
    .v_position_du_curseur(v_pos),
    .vga_vs               (vga_vs),
    .vecteur_map          (vecteur_map),
    .busy                 (busy),
    .done                 (done),
    .err_geom             (err_geom),
    .generation           (generation)
  );

  always #5 clk_50 = ~clk_50;

  always @(negedge clk_50) if (busy) busy_cycles++;

  function automatic logic [MB-1:0] cells(input int a, input int b = -1,
                                          input int c = -1, input int d = -1);
    logic [MB-1:0] m = '0;
    if (a >= 0) m[a] = 1'b1;
    if (b >= 0) m[b] = 1'b1;
    if (c >= 0) m[c] = 1'b1;
    if (d >= 0) m[d] = 1'b1;
    return m;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_map(input string name, input logic [MB-1:0] act, input logic [MB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got low64=%h expected low64=%h", name, act[63:0], exp[63:0]);
    end
  endtask

  // Monitor: every done must match the oldest expected commit.
  always @(negedge clk_50) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no commit (generation=%0d)",
                 generation);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_map("commit_map", vecteur_map, e.map);
        check_val("commit_gen", 32'(generation), 32'(e.gen));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic toggle_at(input int h, input int v);
    h_pos = h; v_pos = v; toggle = 1'b1;
    tick();
    toggle = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic pulse_vs();
    vga_vs = 1'b1;
    tick(4);
    vga_vs = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check_val("idle_in_time", 32'(busy), 0);
  endtask

  task automatic run_step(input logic [MB-1:0] em, input int eg, input int n);
    exp_q.push_back('{em, GW'(eg)});
    step = 1'b1;
    tick();
    step = 1'b0;
    tick(n + 4);
    check_val("wait_vs_busy", 32'(busy), 1);
    check_val("pre_vs_gen", 32'(generation), 32'(eg - 1));
    pulse_vs();
    wait_idle();
  endtask

  initial begin
    int bc0;
    tick(3);
    reset = 1'b0;
    tick();
    check_map("reset_map", vecteur_map, '0);
    check_val("reset_gen", 32'(generation), 0);
    check_val("reset_busy", 32'(busy), 0);
    check_val("reset_done", 32'(done), 0);
    check_val("reset_err", 32'(err_geom), 0);

    // Blinker, with an early VS edge during compute and a toggle while busy.
    toggle_at(1, 2); toggle_at(2, 2); toggle_at(3, 2);
    check_map("blinker_seed", vecteur_map, cells(11, 12, 13));
    exp_q.push_back('{cells(7, 12, 17), GW'(1)});
    bc0 = busy_cycles;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick(3);
    vga_vs = 1'b1;
    tick(4);
    vga_vs = 1'b0;
    tick(30);
    check_val("early_vs_busy", 32'(busy), 1);
    check_val("early_vs_gen", 32'(generation), 0);
    check_map("early_vs_map", vecteur_map, cells(11, 12, 13));
    toggle_at(0, 0);
    pulse_vs();
    wait_idle();
    check_map("blinker_map", vecteur_map, cells(7, 12, 17));
    checks++;
    if (busy_cycles - bc0 < 26) begin
      errors++;
      $display("FAIL busy_len: got %0d cycles expected at least 26", busy_cycles - bc0);
    end

    // Block stability in 6x6.
    pulse_clear();
    check_map("clear_map", vecteur_map, '0);
    check_val("clear_gen", 32'(generation), 0);
    largeur_grille = 32'd6;
    hauteur_grille = 32'd6;
    toggle_at(1, 1); toggle_at(2, 1); toggle_at(1, 2); toggle_at(2, 2);
    check_map("block_seed", vecteur_map, cells(7, 8, 13, 14));
    for (int g = 1; g <= 3; g++) run_step(cells(7, 8, 13, 14), g, 36);

    // Top-edge row: dead edge vs torus.
    pulse_clear();
    largeur_grille = 32'd5;
    hauteur_grille = 32'd5;
    toggle_at(1, 0); toggle_at(2, 0); toggle_at(3, 0);
`ifdef JDV_TORUS_EN
    edge_exp = cells(2, 7, 22);
`else
    edge_exp = cells(2, 7);
`endif
    run_step(edge_exp, 1, 25);

    // Invalid geometry.
    largeur_grille = 32'd40;
    hauteur_grille = 32'd30;
    tick(2);
    check_val("err_40x30", 32'(err_geom), 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick(3);
    check_val("invalid_step_busy", 32'(busy), 0);
    largeur_grille = 32'd2;
    hauteur_grille = 32'd10;
    tick(2);
    check_val("err_2x10", 32'(err_geom), 1);
    toggle_at(0, 0);
    check_map("invalid_toggle_map", vecteur_map, edge_exp);
    largeur_grille = 32'd5;
    hauteur_grille = 32'd5;
    tick(2);
    check_val("err_5x5", 32'(err_geom), 0);

    // clear + toggle + step together: clear alone wins.
    h_pos = 0; v_pos = 0;
    clear = 1'b1; toggle = 1'b1; step = 1'b1;
    tick();
    clear = 1'b0; toggle = 1'b0; step = 1'b0;
    check_map("prio_map", vecteur_map, '0);
    check_val("prio_gen", 32'(generation), 0);
    tick(3);
    check_val("prio_busy", 32'(busy), 0);

    // Reset mid-compute, then VS must not commit anything.
    toggle_at(1, 1); toggle_at(2, 1); toggle_at(3, 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick(5);
    reset = 1'b1;
    #1;
    check_map("midreset_map", vecteur_map, '0);
    check_val("midreset_gen", 32'(generation), 0);
    check_val("midreset_busy", 32'(busy), 0);
    check_val("midreset_done", 32'(done), 0);
    tick(2);
    reset = 1'b0;
    tick();
    pulse_vs();
    tick(10);
    check_val("post_reset_busy", 32'(busy), 0);
    check_val("post_reset_gen", 32'(generation), 0);
    check_map("post_reset_map", vecteur_map, '0);

    check_val("commits_all_seen", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
